// File: rtl/prime_numbers.sv
// rtl/prime_numbers.sv - registered prime/composite classifier for a 4-bit operand with saturating prime counter
module prime_numbers #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             a,
    input  logic                   in_valid,
    input  logic                   clear,
    output logic                   x,
    output logic                   is_composite,
    output logic                   out_valid,
    output logic [COUNT_WIDTH-1:0] prime_count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic a_prime;
    logic a_composite;

    // 0 and 1 fall into neither class.
    always_comb begin
        a_prime     = 1'b0;
        a_composite = 1'b0;
        case (a)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: a_prime     = 1'b1;
            4'd0, 4'd1:                           a_composite = 1'b0;
            default:                              a_composite = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x            <= 1'b0;
            is_composite <= 1'b0;
            out_valid    <= 1'b0;
            prime_count  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x            <= a_prime;
                is_composite <= a_composite;
            end
            // clear wins over a same-cycle prime increment.
            if (clear) begin
                prime_count <= '0;
            end else if (in_valid && a_prime && (prime_count != COUNT_MAX)) begin
                prime_count <= prime_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prime_numbers.sv
// tb/tb_prime_numbers.sv - randomized and directed self-checking bench for prime_numbers
module tb_prime_numbers;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic       in_valid;
    logic       clear;
    logic       x, is_composite, out_valid;
    logic [7:0] prime_count;
    logic       x2, is_composite2, out_valid2;
    logic [1:0] prime_count2;

    int n_cmp = 0;
    int n_err = 0;

    logic ref_x, ref_comp, ref_ov;
    int   ref_c8, ref_c2;

    always #5 clk = ~clk;

    prime_numbers #(.COUNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .clear(clear),
        .x(x), .is_composite(is_composite), .out_valid(out_valid), .prime_count(prime_count)
    );

    prime_numbers #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .clear(clear),
        .x(x2), .is_composite(is_composite2), .out_valid(out_valid2), .prime_count(prime_count2)
    );

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("x",              {15'b0, x},             {15'b0, ref_x});
        chk("is_composite",   {15'b0, is_composite},  {15'b0, ref_comp});
        chk("out_valid",      {15'b0, out_valid},     {15'b0, ref_ov});
        chk("prime_count",    {8'b0, prime_count},    16'(ref_c8));
        chk("exclusive",      {15'b0, x & is_composite}, 16'h0);
        chk("x_w2",           {15'b0, x2},            {15'b0, ref_x});
        chk("is_composite_w2",{15'b0, is_composite2}, {15'b0, ref_comp});
        chk("out_valid_w2",   {15'b0, out_valid2},    {15'b0, ref_ov});
        chk("prime_count_w2", {14'b0, prime_count2},  16'(ref_c2));
    endtask

    task automatic model_reset();
        ref_x = 1'b0; ref_comp = 1'b0; ref_ov = 1'b0; ref_c8 = 0; ref_c2 = 0;
    endtask

    task automatic step(input logic [3:0] av, input logic v, input logic c);
        @(negedge clk);
        a = av; in_valid = v; clear = c;
        @(posedge clk);
        #1;
        if (c) begin
            ref_c8 = 0; ref_c2 = 0;
        end else if (v && is_prime(int'(av))) begin
            if (ref_c8 < 255) ref_c8++;
            if (ref_c2 < 3)   ref_c2++;
        end
        if (v) begin
            ref_x    = is_prime(int'(av));
            ref_comp = (av >= 4'd4) && !is_prime(int'(av));
        end
        ref_ov = v;
        check_all();
    endtask

    initial begin
        logic [1:0] w2_seq [5];
        logic [3:0] primes [6];
        w2_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        primes = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};

        rst_n = 1'b1; a = 4'd0; in_valid = 1'b0; clear = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();

        // samples offered during reset must be ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a = 4'd3; in_valid = 1'b1;
            @(posedge clk);
            #1 check_all();
        end
        rst_n = 1'b1; in_valid = 1'b0;

        for (int v = 0; v < 16; v++) step(4'(v), 1'b1, 1'b0);
        chk("sweep_count", {8'b0, prime_count}, 16'd6);

        step(4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'(i), 1'b0, 1'b0);
        chk("hold_x", {15'b0, x}, 16'd1);

        step(4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(primes[i], 1'b1, 1'b0);
        chk("count_before_clear", {8'b0, prime_count}, 16'd4);
        step(4'd11, 1'b1, 1'b1);
        chk("clear_count", {8'b0, prime_count}, 16'd0);
        chk("clear_x", {15'b0, x}, 16'd1);

        for (int i = 0; i < 5; i++) begin
            step(primes[i], 1'b1, 1'b0);
            chk("w2_sat_seq", {14'b0, prime_count2}, {14'b0, w2_seq[i]});
        end

        for (int i = 0; i < 300; i++)
            step(4'($urandom_range(15)), 1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0));

        // asynchronous reset between edges drops the in-flight result
        step(4'd13, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        a = 4'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 check_all();
        rst_n = 1'b1; in_valid = 1'b0;
        step(4'd2, 1'b1, 1'b0);
        chk("post_reset_count", {8'b0, prime_count}, 16'd1);

        // long run without clear drives the 8-bit counter into saturation
        for (int i = 0; i < 1200; i++)
            step(4'($urandom_range(15)), 1'($urandom_range(3) != 0), 1'b0);
        chk("sat8", {8'b0, prime_count}, 16'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prime_numbers.md
PRIME_NUMBERS -- requirements
Module: prime_numbers

Interface
Parameters:
REQ-001 The block SHALL have one parameter: COUNT_WIDTH, default 8, the width of prime_count; legal range 2 to 16.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have a  input  4  unsigned operand, 0 to 15.
REQ-005 The block SHALL have in_valid  input  1  qualifies a as a sample this cycle.
REQ-006 The block SHALL have clear  input  1  synchronous clear of prime_count.
REQ-007 The block SHALL have x  output  1  registered flag, 1 = last accepted a is prime.
REQ-008 The block SHALL have is_composite  output  1  registered flag, 1 = last accepted a is composite (4,6,8,9,10,12,14,15).
REQ-009 The block SHALL have out_valid  output  1  registered, pulses high 1 cycle after each accepted sample.
REQ-010 The block SHALL have prime_count  output  COUNT_WIDTH  saturating count of accepted prime samples.

Function
REQ-011 The prime set SHALL be exactly {2,3,5,7,11,13}; the values 0 and 1 SHALL be neither prime nor composite.
REQ-012 A sample SHALL be accepted on a rising clk edge when in_valid=1.
REQ-013 On acceptance, x and is_composite SHALL take the classification of a with 1-cycle latency, and out_valid SHALL be 1 for exactly that following cycle.
REQ-014 x and is_composite SHALL never be 1 at the same time.
REQ-015 When in_valid=0, x and is_composite SHALL hold their previous values, and out_valid SHALL be 0 in the next cycle.
REQ-016 On an accepted prime sample, prime_count SHALL increment by 1; at 2^COUNT_WIDTH-1 it SHALL saturate and hold, with no wrap-around.
REQ-017 clear=1 SHALL set prime_count to 0 on the next edge and SHALL take priority over a simultaneous prime increment.
REQ-018 clear SHALL NOT affect x, is_composite or out_valid; a sample accepted in the same cycle as clear SHALL still be classified.
REQ-019 Back-to-back samples (in_valid held high) SHALL each be classified, with one result per cycle and no stall.
REQ-020 The classification SHALL be pure combinational decode of a that feeds the registers; there SHALL be no internal state besides x, is_composite, out_valid and prime_count.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force x=0, is_composite=0, out_valid=0 and prime_count=0.
REQ-022 While rst_n=0, all samples SHALL be ignored.
REQ-023 The first sample SHALL be accepted on the first rising edge at which rst_n=1 and in_valid=1.
REQ-024 Reset asserted mid-stream SHALL discard any in-flight result, so that out_valid does not pulse for that sample.

Verification
REQ-025 Sweep a=0..15 with in_valid=1, one value per cycle -> x=1 exactly for 2,3,5,7,11,13; is_composite=1 for 4,6,8,9,10,12,14,15; both 0 for 0 and 1; prime_count=6 at the end.
REQ-026 Accept a=7, then hold in_valid=0 for 3 cycles -> x stays 1, out_valid=1 for one cycle then 0.
REQ-027 With COUNT_WIDTH=2, feed 5 consecutive primes -> prime_count reads 1,2,3,3,3.
REQ-028 Assert clear and in_valid with a=11 together while prime_count=4 -> prime_count=0 and x=1 after the edge.
REQ-029 Drive rst_n low between clock edges after a=13 was accepted -> x, out_valid and prime_count go to 0 immediately; after release, a=2 gives x=1 and prime_count=1.
